// File: rtl/ir_car_scheduler.sv
// Frame-paced scheduler sharing one IR transmitter among four cars.
// Each frame serves every enabled slot once, lowest index first.
module ir_car_scheduler #(
    parameter logic [7:0] BASE_ADDR   = 8'h90,
    parameter int         FRAME_MAX   = 5000000,
    parameter int         TIMEOUT_MAX = 4000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    input  logic       PACK_DONE,
    output logic [3:0] CAR_SEL,
    output logic [3:0] COMMAND,
    output logic       PACK_STROBE,
    output logic       PACK_GEN_EN,
    output logic       OVERRUN,
    output logic       TIMEOUT
);

    localparam int FW = $clog2(FRAME_MAX);
    localparam int WW = $clog2(TIMEOUT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    slot_q [4];
    logic [7:0]    slot_d [4];
    logic [FW-1:0] frame_q, frame_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    car_q, car_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          strobe_q, strobe_d;
    logic          gen_q, gen_d;

    logic       tick, load, wait_exit, wait_tmo;
    logic       first_vld, next_vld;
    logic [1:0] first_idx, next_idx;

    always_comb begin
        tick    = (frame_q == FW'(FRAME_MAX - 1));
        frame_d = tick ? '0 : frame_q + 1'b1;

        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
            if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'(i))
                slot_d[i] = BUS_DATA;
        end

        // Scan downward so the lowest matching index wins.
        first_vld = 1'b0;
        first_idx = 2'd0;
        next_vld  = 1'b0;
        next_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_q[i][7]) begin
                first_vld = 1'b1;
                first_idx = 2'(i);
            end
            if (slot_q[i][7] && 2'(i) > idx_q) begin
                next_vld = 1'b1;
                next_idx = 2'(i);
            end
        end

        wait_tmo  = (wait_q == WW'(TIMEOUT_MAX));
        wait_exit = PACK_DONE || wait_tmo;

        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = '0;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick && first_vld) begin
                    load  = 1'b1;
                    idx_d = first_idx;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                wait_d  = WW'(1);
            end
            S_WAIT: begin
                if (wait_exit) begin
                    if (next_vld) begin
                        load  = 1'b1;
                        idx_d = next_idx;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load)
            state_d = S_LOAD;

        // Outputs are registered from the next state; the command is
        // snapshotted at selection so later slot writes cannot disturb it.
        strobe_d = load;
        gen_d    = load || (state_d == S_WAIT);
        car_d    = 4'b0000;
        cmd_d    = 4'b0000;
        if (load) begin
            car_d = 4'b1000 >> idx_d;
            cmd_d = slot_q[idx_d][3:0];
        end else if (state_d == S_WAIT) begin
            car_d = car_q;
            cmd_d = cmd_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            wait_q   <= '0;
            idx_q    <= 2'd0;
            car_q    <= 4'b0000;
            cmd_q    <= 4'b0000;
            strobe_q <= 1'b0;
            gen_q    <= 1'b0;
            for (int i = 0; i < 4; i++)
                slot_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            car_q    <= car_d;
            cmd_q    <= cmd_d;
            strobe_q <= strobe_d;
            gen_q    <= gen_d;
            for (int i = 0; i < 4; i++)
                slot_q[i] <= slot_d[i];
        end
    end

    assign CAR_SEL     = car_q;
    assign COMMAND     = cmd_q;
    assign PACK_STROBE = strobe_q;
    assign PACK_GEN_EN = gen_q;
    assign OVERRUN     = tick && (state_q != S_IDLE);
    assign TIMEOUT     = (state_q == S_WAIT) && wait_tmo && !PACK_DONE;

endmodule

// File: tb/tb_ir_car_scheduler.sv
// Scoreboard bench for ir_car_scheduler: expected strobes, timeouts
// and overruns are queued with their cycle and matched as they appear.
module tb_ir_car_scheduler;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic       BUS_WE = 1'b0;
    logic       PACK_DONE = 1'b0;
    logic [3:0] CAR_SEL, COMMAND;
    logic       PACK_STROBE, PACK_GEN_EN, OVERRUN, TIMEOUT;

    ir_car_scheduler #(
        .BASE_ADDR  (8'h90),
        .FRAME_MAX  (100),
        .TIMEOUT_MAX(50)
    ) dut (
        .CLK        (clk),
        .RST        (RST),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA   (BUS_DATA),
        .BUS_WE     (BUS_WE),
        .PACK_DONE  (PACK_DONE),
        .CAR_SEL    (CAR_SEL),
        .COMMAND    (COMMAND),
        .PACK_STROBE(PACK_STROBE),
        .PACK_GEN_EN(PACK_GEN_EN),
        .OVERRUN    (OVERRUN),
        .TIMEOUT    (TIMEOUT)
    );

    always #5 clk = ~clk;

    localparam int K_STB = 0;
    localparam int K_TMO = 1;
    localparam int K_OVR = 2;

    typedef struct {
        int kind;
        int cyc;
        int car;
        int cmd;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_dly = 0;
    int  done_cnt = 0;
    int  car_nz = 0;
    int  r0, l0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int car,
                        input int cmd);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.car  = car;
        e.cmd  = cmd;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int car, input int cmd);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            if (kind == K_STB) begin
                chk("ev_car", car, e.car);
                chk("ev_cmd", cmd, e.cmd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!RST) begin
            if (CAR_SEL != 4'b0000) car_nz++;
            if (PACK_STROBE) pop_cmp(K_STB, int'(CAR_SEL), int'(COMMAND));
            if (TIMEOUT)     pop_cmp(K_TMO, 0, 0);
            if (OVERRUN)     pop_cmp(K_OVR, 0, 0);
        end
    end

    // Transmitter model: PACK_DONE pulses done_dly cycles after a strobe.
    initial begin
        forever begin
            @(negedge clk);
            PACK_DONE = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) PACK_DONE = 1'b1;
            end
            if (PACK_STROBE && done_dly > 0) done_cnt = done_dly;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        r0 = cyc;
        l0 = r0 + 100;
        RST = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_DATA = d;
        BUS_WE   = 1'b1;
        @(negedge clk);
        BUS_WE   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_car"}, int'(CAR_SEL), 0);
        chk({tag, "_cmd"}, int'(COMMAND), 0);
        chk({tag, "_gen"}, int'(PACK_GEN_EN), 0);
        chk({tag, "_stb"}, int'(PACK_STROBE), 0);
    endtask

    initial begin
        int base;

        do_reset();
        chk_idle("reset");
        chk("reset_tmo", int'(TIMEOUT), 0);
        chk("reset_ovr", int'(OVERRUN), 0);

        // Two cars served in index order, done after 10 cycles.
        bus_wr(8'h90, 8'h85);
        bus_wr(8'h92, 8'h83);
        bus_wr(8'h94, 8'hFF);
        bus_wr(8'h8F, 8'hFF);
        done_dly = 10;
        push(K_STB, l0, 8, 5);
        push(K_STB, l0 + 11, 2, 3);
        wait_until(l0 + 5);
        chk("a_wait_car", int'(CAR_SEL), 8);
        chk("a_wait_cmd", int'(COMMAND), 5);
        chk("a_wait_gen", int'(PACK_GEN_EN), 1);
        chk("a_wait_stb", int'(PACK_STROBE), 0);
        wait_until(l0 + 21);
        chk("a_blue_gen", int'(PACK_GEN_EN), 1);
        chk("a_blue_car", int'(CAR_SEL), 2);
        wait_until(l0 + 22);
        chk_idle("a_end");
        wait_until(l0 + 30);
        chk("a_sb_empty", sb.size(), 0);

        // All slots disabled: nothing happens for 300 cycles.
        do_reset();
        base = car_nz;
        wait_until(r0 + 300);
        chk("b_car_idle", car_nz - base, 0);
        chk("b_sb_empty", sb.size(), 0);

        // No PACK_DONE: timeout, then retry next frame.
        do_reset();
        bus_wr(8'h90, 8'h81);
        done_dly = 0;
        push(K_STB, l0, 8, 1);
        push(K_TMO, l0 + 50, 0, 0);
        push(K_STB, l0 + 100, 8, 1);
        push(K_TMO, l0 + 150, 0, 0);
        wait_until(l0 + 51);
        chk("c_idle_car", int'(CAR_SEL), 0);
        chk("c_idle_gen", int'(PACK_GEN_EN), 0);
        wait_until(l0 + 155);
        chk("c_sb_empty", sb.size(), 0);

        // Frame overrun while GREEN still waiting; tick is dropped.
        do_reset();
        bus_wr(8'h90, 8'h81);
        bus_wr(8'h91, 8'h84);
        push(K_STB, l0, 8, 1);
        push(K_TMO, l0 + 50, 0, 0);
        push(K_STB, l0 + 51, 4, 4);
        push(K_OVR, l0 + 99, 0, 0);
        push(K_TMO, l0 + 101, 0, 0);
        push(K_STB, l0 + 200, 8, 1);
        wait_until(l0 + 102);
        chk("d_idle_gen", int'(PACK_GEN_EN), 0);
        wait_until(l0 + 205);
        chk("d_sb_empty", sb.size(), 0);

        // Slot rewrite mid-packet only affects the next frame.
        do_reset();
        bus_wr(8'h90, 8'h85);
        done_dly = 20;
        push(K_STB, l0, 8, 5);
        push(K_STB, l0 + 100, 8, 2);
        wait_until(l0 + 3);
        bus_wr(8'h90, 8'h82);
        wait_until(l0 + 10);
        chk("e_hold_cmd", int'(COMMAND), 5);
        chk("e_hold_car", int'(CAR_SEL), 8);
        wait_until(l0 + 20);
        chk("e_last_cmd", int'(COMMAND), 5);
        chk("e_last_gen", int'(PACK_GEN_EN), 1);
        wait_until(l0 + 21);
        chk("e_idle_gen", int'(PACK_GEN_EN), 0);
        wait_until(l0 + 125);
        chk("e_sb_empty", sb.size(), 0);

        // Reset during GREEN wait clears outputs and slots.
        do_reset();
        bus_wr(8'h91, 8'h87);
        done_dly = 0;
        push(K_STB, l0, 4, 7);
        wait_until(l0 + 10);
        chk("f_pre_car", int'(CAR_SEL), 4);
        RST = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        chk_idle("f_rst");
        @(negedge clk);
        r0 = cyc;
        RST = 1'b0;
        wait_until(r0 + 250);
        chk("f_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_car_scheduler.md
IR_CAR_SCHEDULER -- requirements
Module: ir_car_scheduler

Interface
REQ-001 Parameter BASE_ADDR, 8'h90, first of four consecutive bus addresses holding per-car slot registers (RED, GREEN, BLUE, YELLOW, in that order).
REQ-002 Parameter FRAME_MAX, 5000000, frame period in CLK cycles (10 Hz at 50 MHz).
REQ-003 Parameter TIMEOUT_MAX, 4000000, maximum cycles to wait for PACK_DONE before abandoning a packet.
REQ-004 CLK  in  1  system clock; single clock domain; all logic on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 BUS_ADDR  in  8  processor bus address.
REQ-007 BUS_DATA  in  8  processor bus write data.
REQ-008 BUS_WE  in  1  processor bus write enable.
REQ-009 PACK_DONE  in  1  one-cycle pulse from the shared IR transmitter when the current packet has finished.
REQ-010 CAR_SEL  out  4  one-hot car being served: RED=4'b1000, GREEN=4'b0100, BLUE=4'b0010, YELLOW=4'b0001; 4'b0000 when none.
REQ-011 COMMAND  out  4  direction command for the car being served.
REQ-012 PACK_STROBE  out  1  one-cycle packet start pulse to the transmitter.
REQ-013 PACK_GEN_EN  out  1  transmitter enable, high while a packet is in flight.
REQ-014 OVERRUN  out  1  one-cycle pulse when a frame tick arrives while a frame is still in progress.
REQ-015 TIMEOUT  out  1  one-cycle pulse when a packet is abandoned after TIMEOUT_MAX cycles.

Function
REQ-016 Slot register i (i=0..3) SHALL be written with BUS_DATA when BUS_WE=1 and BUS_ADDR==BASE_ADDR+i; bit7=enable, bits3:0=command, bits6:4 ignored; other addresses SHALL have no effect.
REQ-017 Frame counter SHALL count 0..FRAME_MAX-1 continuously, independent of slot state; frame tick = cycle in which count==FRAME_MAX-1.
REQ-018 FSM states: IDLE, LOAD, WAIT; encoding is free.
REQ-019 IDLE: on a frame tick with at least one slot enabled, go to LOAD serving the lowest-index enabled slot; otherwise remain in IDLE.
REQ-020 LOAD (exactly one cycle): PACK_STROBE=1, PACK_GEN_EN=1, CAR_SEL=one-hot of served slot, COMMAND=snapshot of that slot's command; next state WAIT.
REQ-021 WAIT: hold CAR_SEL, COMMAND, PACK_GEN_EN=1, PACK_STROBE=0; count cycles from 1.
REQ-022 WAIT exit on PACK_DONE=1, or on the cycle the wait count reaches TIMEOUT_MAX (TIMEOUT=1 that cycle, only if PACK_DONE=0 that cycle).
REQ-023 On WAIT exit, go to LOAD for the next enabled slot with a higher index, evaluated on that cycle; if none, go to IDLE.
REQ-024 In IDLE: CAR_SEL=0, COMMAND=0, PACK_STROBE=0, PACK_GEN_EN=0.
REQ-025 Slot writes during LOAD/WAIT SHALL NOT change the in-flight COMMAND or CAR_SEL; they take effect at the next selection.
REQ-026 Disabling the in-flight slot SHALL NOT abort its packet.
REQ-027 A frame tick seen in LOAD or WAIT SHALL pulse OVERRUN for that cycle and SHALL be discarded (no queued frame).
REQ-028 PACK_DONE in IDLE or LOAD SHALL be ignored.
REQ-029 Each enabled slot SHALL receive at most one packet per frame; slots are served strictly in index order.

Reset
REQ-030 RST=1 on a rising edge SHALL, in that cycle: clear all slot registers to 8'h00, frame counter and wait counter to 0, FSM to IDLE, all outputs to 0.
REQ-031 Reset asserted mid-packet SHALL drop PACK_GEN_EN and CAR_SEL to 0 on the next edge with no further PACK_STROBE.
REQ-032 After reset release, the first frame tick SHALL occur FRAME_MAX cycles later.

Verification (FRAME_MAX=100, TIMEOUT_MAX=50)
REQ-033 Write 8'h85 to 0x90, 8'h83 to 0x92; PACK_DONE 10 cycles after each strobe -> tick at T: LOAD RED cmd 5 at T+1; BLUE cmd 3 at T+12; IDLE at T+23.
REQ-034 All slots disabled for 300 cycles -> PACK_STROBE never asserted, CAR_SEL stays 0.
REQ-035 RED enabled, PACK_DONE never driven -> TIMEOUT pulse 50 cycles after LOAD, FSM to IDLE; next frame retries RED.
REQ-036 RED enabled, PACK_DONE withheld until after next tick -> OVERRUN pulses on that tick; no second strobe until the following frame.
REQ-037 Write 8'h82 to 0x90 while RED is in WAIT with cmd 5 -> COMMAND stays 5 until done; next frame sends 2.
REQ-038 Assert RST during GREEN WAIT -> next cycle all outputs 0, slots cleared, no strobe at following tick.
